// File: rtl/mccpu_pkg.sv
// Shared encodings for the multicycle MIPS-subset core: opcodes, functs, FSM states, ALU ops.
package mccpu_pkg;

    localparam logic [5:0] OpR    = 6'h00;
    localparam logic [5:0] OpJ    = 6'h02;
    localparam logic [5:0] OpJal  = 6'h03;
    localparam logic [5:0] OpBne  = 6'h05;
    localparam logic [5:0] OpAddi = 6'h08;
    localparam logic [5:0] OpXori = 6'h0e;
    localparam logic [5:0] OpLw   = 6'h23;
    localparam logic [5:0] OpSw   = 6'h2b;

    localparam logic [5:0] FnAdd  = 6'h20;
    localparam logic [5:0] FnSub  = 6'h22;
    localparam logic [5:0] FnSlt  = 6'h2a;
    localparam logic [5:0] FnJr   = 6'h08;

    typedef enum logic [2:0] {
        StFetch,
        StDecode,
        StExec,
        StMem,
        StWb,
        StHalt
    } state_e;

    typedef enum logic [1:0] {
        AluAdd,
        AluSub,
        AluXor,
        AluSlt
    } alu_op_e;

endpackage

// File: rtl/mccpu_alu.sv
// Shared combinational ALU: add/sub/xor/signed set-less-than, plus a zero flag on the result.
module mccpu_alu
    import mccpu_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  alu_op_e         op_i,
    output logic [XLEN-1:0] y_o,
    output logic            zero_o
);

    // Result select and zero detect
    always_comb begin
        unique case (op_i)
            AluAdd:  y_o = a_i + b_i;
            AluSub:  y_o = a_i - b_i;
            AluXor:  y_o = a_i ^ b_i;
            AluSlt:  y_o = {{(XLEN-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
            default: y_o = '0;
        endcase
        zero_o = (y_o == '0);
    end

endmodule

// File: rtl/mccpu_core.sv
// Multicycle MIPS-subset core with one shared ALU and a unified valid/ack memory port.
// Optional MCCPU_TRAP_EN: unknown instructions halt the core instead of retiring as NOPs.
module mccpu_core
    import mccpu_pkg::*;
#(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     NREGS    = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic            mem_ack,
    output logic [XLEN-1:0] pc,
    output logic            retire,
    output logic            halted
);

    localparam int unsigned     RW    = $clog2(NREGS);
    localparam logic [RW-1:0]   RaIdx = RW'(31);

    state_e            state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d, a_q, a_d, b_q, b_d;
    logic [XLEN-1:0]   alu_out_q, alu_out_d, mdr_q, mdr_d;
    logic [31:0]       ir_q, ir_d;
    logic [XLEN-1:0]   regs_q [NREGS];
    logic [XLEN-1:0]   regs_d [NREGS];
    logic              mem_req_q, mem_req_d, mem_we_q, mem_we_d;
    logic [XLEN-1:0]   mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
    logic              retire_q, retire_d, halted_q, halted_d;

    logic [5:0]        opcode, funct;
    logic [RW-1:0]     rs_idx, rt_idx, rd_idx, dest_idx;
    logic [XLEN-1:0]   imm_sext, imm_zext, br_off, jump_target;
    logic [XLEN-1:0]   alu_a, alu_b, alu_y;
    alu_op_e           alu_op;
    logic              alu_zero, unknown;

    assign opcode      = ir_q[31:26];
    assign funct       = ir_q[5:0];
    assign rs_idx      = ir_q[21 +: RW];
    assign rt_idx      = ir_q[16 +: RW];
    assign rd_idx      = ir_q[11 +: RW];
    assign imm_sext    = {{(XLEN-16){ir_q[15]}}, ir_q[15:0]};
    assign imm_zext    = {{(XLEN-16){1'b0}}, ir_q[15:0]};
    assign br_off      = {imm_sext[XLEN-3:0], 2'b00};
    assign jump_target = {pc_q[XLEN-1:28], ir_q[25:0], 2'b00};
    assign dest_idx    = (opcode == OpR) ? rd_idx : (opcode == OpJal) ? RaIdx : rt_idx;

    mccpu_alu #(.XLEN(XLEN)) u_alu (
        .a_i    (alu_a),
        .b_i    (alu_b),
        .op_i   (alu_op),
        .y_o    (alu_y),
        .zero_o (alu_zero)
    );

    // Next-state, datapath and register-file update for the current FSM state
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        a_d       = a_q;
        b_d       = b_q;
        alu_out_d = alu_out_q;
        mdr_d     = mdr_q;
        regs_d    = regs_q;
        retire_d  = 1'b0;
        alu_a     = a_q;
        alu_b     = b_q;
        alu_op    = AluAdd;
        unknown   = 1'b0;

        case (state_q)
            StFetch: begin
                if (mem_req_q && mem_ack) begin
                    ir_d    = mem_rdata[31:0];
                    pc_d    = pc_q + XLEN'(4);
                    state_d = StDecode;
                end
            end
            StDecode: begin
                a_d     = regs_q[rs_idx];
                b_d     = regs_q[rt_idx];
                state_d = StExec;
            end
            StExec: begin
                case (opcode)
                    OpR: begin
                        case (funct)
                            FnAdd: alu_op = AluAdd;
                            FnSub: alu_op = AluSub;
                            FnSlt: alu_op = AluSlt;
                            FnJr:  alu_op = AluAdd;
                            default: unknown = 1'b1;
                        endcase
                        if (funct == FnJr) begin
                            pc_d     = a_q;
                            retire_d = 1'b1;
                            state_d  = StFetch;
                        end else if (!unknown) begin
                            alu_out_d = alu_y;
                            state_d   = StWb;
                        end
                    end
                    OpAddi: begin
                        alu_b     = imm_sext;
                        alu_out_d = alu_y;
                        state_d   = StWb;
                    end
                    OpXori: begin
                        alu_b     = imm_zext;
                        alu_op    = AluXor;
                        alu_out_d = alu_y;
                        state_d   = StWb;
                    end
                    OpLw, OpSw: begin
                        alu_b     = imm_sext;
                        alu_out_d = alu_y;
                        state_d   = StMem;
                    end
                    OpBne: begin
                        alu_op = AluSub;
                        if (!alu_zero) pc_d = pc_q + br_off;
                        retire_d = 1'b1;
                        state_d  = StFetch;
                    end
                    OpJ: begin
                        pc_d     = jump_target;
                        retire_d = 1'b1;
                        state_d  = StFetch;
                    end
                    OpJal: begin
                        // pc_q already points past the JAL: that is the link value
                        alu_out_d = pc_q;
                        pc_d      = jump_target;
                        state_d   = StWb;
                    end
                    default: unknown = 1'b1;
                endcase
                if (unknown) begin
`ifdef MCCPU_TRAP_EN
                    state_d = StHalt;
`else
                    retire_d = 1'b1;
                    state_d  = StFetch;
`endif
                end
            end
            StMem: begin
                if (mem_req_q && mem_ack) begin
                    if (opcode == OpSw) begin
                        retire_d = 1'b1;
                        state_d  = StFetch;
                    end else begin
                        mdr_d   = mem_rdata;
                        state_d = StWb;
                    end
                end
            end
            StWb: begin
                if (dest_idx != '0) regs_d[dest_idx] = (opcode == OpLw) ? mdr_q : alu_out_q;
                retire_d = 1'b1;
                state_d  = StFetch;
            end
            StHalt: state_d = StHalt;
            default: state_d = StFetch;
        endcase
    end

    // Memory-port outputs are registered from the upcoming state so they are glitch-free
    always_comb begin
        mem_req_d   = (state_d == StFetch) || (state_d == StMem);
        mem_we_d    = (state_d == StMem) && (opcode == OpSw);
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if (state_d == StFetch) begin
            mem_addr_d = pc_d;
        end else if (state_d == StMem) begin
            mem_addr_d  = alu_out_d;
            mem_wdata_d = b_q;
        end
        halted_d = (state_d == StHalt);
    end

    // State, datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StFetch;
            pc_q        <= RESET_PC;
            ir_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            alu_out_q   <= '0;
            mdr_q       <= '0;
            regs_q      <= '{default: '0};
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            retire_q    <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            a_q         <= a_d;
            b_q         <= b_d;
            alu_out_q   <= alu_out_d;
            mdr_q       <= mdr_d;
            regs_q      <= regs_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            retire_q    <= retire_d;
            halted_q    <= halted_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign pc        = pc_q;
    assign retire    = retire_q;
    assign halted    = halted_q;

endmodule

// File: doc/mccpu_core.md
Name: mccpu_core

Overview:
- Parametrised multicycle MIPS-subset CPU core; next generation of the team's single-cycle CPU.
- Executes each instruction over 3-5 states, sharing one ALU and one unified memory port with a valid/ack handshake, so memory may stall.
- Sits between the testbench/top and a unified instruction+data memory; replaces the single-cycle top for memories with wait states.

Parameters:
- XLEN, 32, datapath/register width (32 or 64); immediates sign-extend to XLEN.
- NREGS, 32, register count (power of two, 8..32); register index is log2(NREGS) bits; $0 hardwired zero.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- mem_req  out  1  memory request valid; held until mem_ack
- mem_we  out  1  1 = store, 0 = read; stable while mem_req
- mem_addr  out  XLEN  byte address (word-aligned)
- mem_wdata  out  XLEN  store data
- mem_rdata  in  XLEN  read data, valid when mem_ack
- mem_ack  in  1  transfer completes in the cycle sampled high with mem_req
- pc  out  XLEN  current PC
- retire  out  1  one-cycle pulse when an instruction completes
- halted  out  1  core stopped (trap only, see Optional Feature)

Behaviour:
- Reset (asynchronous, rst_n=0): pc=RESET_PC; state=FETCH; all registers 0; mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0; retire=0; halted=0. Reset mid-transaction abandons the request immediately; no register write occurs.
- Supported instructions: ADD, SUB, SLT, JR (R-type); ADDI, XORI, LW, SW, BNE (I-type); J, JAL. Instruction word is 32 bits; the low 32 bits of mem_rdata are used.
- FETCH: mem_req=1, mem_we=0, mem_addr=pc. On ack: IR<=rdata[31:0]; pc<=pc+4; go to DECODE. No ack: hold, outputs stable.
- DECODE: A<=R[rs], B<=R[rt]; imm sign-extended (XORI zero-extended); go to EXEC.
- EXEC:
  - R-type/ADDI/XORI: ALUOut<=result; go to WB.
  - LW/SW: ALUOut<=A+imm; go to MEM.
  - BNE: if A!=B, pc<=pc+(imm<<2); retire; go to FETCH.
  - J: pc<={pc[XLEN-1:28], target, 2'b00}; retire; go to FETCH.
  - JR: pc<=A; retire; go to FETCH.
  - JAL: ALUOut<=pc (already +4); pc<=jump target; go to WB with dest=$31.
- MEM: mem_req=1, mem_addr=ALUOut, mem_we=SW, mem_wdata=B. On ack: LW -> MDR<=rdata, go to WB; SW -> retire, go to FETCH.
- WB: write R[dest]<=ALUOut (MDR for LW); retire; go to FETCH. dest: rd for R-type, rt for I-type, $31 for JAL. Writes to $0 are ignored. Index bits above log2(NREGS) are dropped.
- Latency with mem_ack tied high: J/JR/BNE 3 cycles, SW 4, R/I-ALU/JAL 4, LW 5. Each ack-wait cycle adds 1.
- Arithmetic: ADD/SUB/ADDI wrap modulo 2^XLEN with no overflow trap. SLT is signed and yields 1 or 0. PC wraps modulo 2^XLEN.
- Unknown opcode or funct: treated as a NOP; retire in EXEC, go to FETCH.

Optional Feature:
- Macro: MCCPU_TRAP_EN.
- Defined: an unknown opcode/funct in EXEC enters state HALT. halted=1, no retire, pc holds the address of the faulting instruction+4, mem_req=0. HALT is left only by reset.
- Undefined: unknown instructions are NOPs; halted is tied 0.

Decomposition:
- Package mccpu_pkg holds: opcode/funct constants (LW 6'h23, SW 6'h2b, J 6'h02, JAL 6'h03, BNE 6'h05, XORI 6'h0e, ADDI 6'h08, R 6'h00; funct ADD 6'h20, SUB 6'h22, SLT 6'h2a, JR 6'h08); state enum {FETCH, DECODE, EXEC, MEM, WB, HALT}; ALU op codes.
- Sub-module mccpu_alu: combinational, XLEN-parametrised; add/sub/xor/slt with a zero flag.
- Register file stays inline.

Test Plan:
- Reset, ack tied 1, program ADDI $1,$0,5; ADDI $2,$0,-3; ADD $3,$1,$2 -> $3=2; retire pulses at cycles 4, 8, 12; pc=12.
- LW/SW with mem_ack delayed 3 cycles: SW $3,0x40($0) then LW $4,0x40($0) -> mem_req held with stable addr 0x40 through waits; $4=2; LW takes 5+3+3 cycles.
- BNE taken/not-taken: $1=5, $2=5 -> falls through to pc+4. With $2=6 and offset -2 -> branches back; loop count verified.
- JAL to 0x100 at pc=0x20 -> $31=0x24, pc=0x100; then JR $31 -> pc=0x24.
- Write to $0 via ADDI $0,$0,7 -> $0 reads 0. SLT $5,$2,$1 with $2=-3, $1=5 -> $5=1.
- rst_n low mid-MEM of an LW -> mem_req drops that cycle, pc=RESET_PC, destination register unchanged. With MCCPU_TRAP_EN, opcode 6'h3f -> halted=1 with no further mem_req.
